// File: rtl/seq_game_pkg.sv
// Shared constants for the repeat-after-me sequence game: FSM encodings,
// code width and a helper that sizes the tick counter.
package seq_game_pkg;

  localparam int CODE_W = 2;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_ADD      = 3'd1;
  localparam state_t ST_SHOW_ON  = 3'd2;
  localparam state_t ST_SHOW_OFF = 3'd3;
  localparam state_t ST_WAIT_IN  = 3'd4;

  // Bits needed for a counter that runs 0..max(a,b,c)-1, never less than one.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/seq_mem.sv
// Sequence storage: DEPTH x W register file, one synchronous write port and
// one combinational read port.
module seq_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 2
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [W-1:0]             wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [W-1:0]             rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; the FSM never reads an entry before writing it.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/random_sequence_game.sv
// Repeat-after-me game FSM: grows a sequence from rnd, plays it back on the
// LED, then checks button presses. Define SEQ_TIMEOUT_EN for a per-press timeout.
module random_sequence_game
  import seq_game_pkg::*;
#(
  parameter int MAX_LEN       = 16,
  parameter int ON_TICKS      = 25_000_000,
  parameter int OFF_TICKS     = 12_500_000,
  parameter int TIMEOUT_TICKS = 250_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CODE_W-1:0]            rnd,
  input  logic                         start,
  input  logic                         btn_valid,
  input  logic [CODE_W-1:0]            btn_code,
  output logic                         led_on,
  output logic [CODE_W-1:0]            led_code,
  output logic                         busy,
  output logic                         round_ok,
  output logic                         game_won,
  output logic                         fail,
  output logic [$clog2(MAX_LEN+1)-1:0] level
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = cnt_width(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS);

  localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
  localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);
`ifdef SEQ_TIMEOUT_EN
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_TICKS - 1);
`endif

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            round_ok_q, round_ok_d;
  logic            game_won_q, game_won_d;
  logic            fail_q, fail_d;
  logic            mem_we;
  logic [CODE_W-1:0] rd_code;
  logic            idx_last;

  seq_mem #(.DEPTH(MAX_LEN), .W(CODE_W)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (len_q[AW-1:0]),
    .wdata (rnd),
    .raddr (idx_q),
    .rdata (rd_code)
  );

  assign idx_last = (LW'(idx_q) + LW'(1)) == len_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    tick_d     = tick_q + TW'(1);
    round_ok_d = 1'b0;
    game_won_d = 1'b0;
    fail_d     = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        idx_d  = '0;
        if (start) state_d = ST_ADD;
      end
      ST_ADD: begin
        mem_we  = 1'b1;
        len_d   = len_q + LW'(1);
        idx_d   = '0;
        tick_d  = '0;
        state_d = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (tick_q == ON_LAST) begin
          tick_d  = '0;
          state_d = ST_SHOW_OFF;
        end
      end
      ST_SHOW_OFF: begin
        if (tick_q == OFF_LAST) begin
          tick_d = '0;
          if (idx_last) begin
            idx_d   = '0;
            state_d = ST_WAIT_IN;
          end else begin
            idx_d   = idx_q + AW'(1);
            state_d = ST_SHOW_ON;
          end
        end
      end
      ST_WAIT_IN: begin
`ifndef SEQ_TIMEOUT_EN
        tick_d = '0;
`endif
        if (btn_valid) begin
          tick_d = '0;
          if (btn_code != rd_code) begin
            fail_d  = 1'b1;
            len_d   = '0;
            state_d = ST_IDLE;
          end else if (!idx_last) begin
            idx_d = idx_q + AW'(1);
          end else begin
            round_ok_d = 1'b1;
            state_d    = ST_IDLE;
            if (len_q == LEN_MAX) begin
              game_won_d = 1'b1;
              len_d      = '0;
            end
          end
        end
`ifdef SEQ_TIMEOUT_EN
        else if (tick_q == TO_LAST) begin
          tick_d  = '0;
          fail_d  = 1'b1;
          len_d   = '0;
          state_d = ST_IDLE;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      tick_q     <= '0;
      round_ok_q <= 1'b0;
      game_won_q <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      tick_q     <= tick_d;
      round_ok_q <= round_ok_d;
      game_won_q <= game_won_d;
      fail_q     <= fail_d;
    end
  end

  assign busy     = state_q != ST_IDLE;
  assign led_on   = state_q == ST_SHOW_ON;
  assign led_code = led_on ? rd_code : '0;
  assign level    = len_q;
  assign round_ok = round_ok_q;
  assign game_won = game_won_q;
  assign fail     = fail_q;

endmodule

// File: tb/tb_random_sequence_game.sv
// Self-checking bench for random_sequence_game: scoreboard queues for LED
// playback codes and press verdicts, one task per scenario.
module tb_random_sequence_game;

  localparam int MAX_LEN       = 4;
  localparam int ON_TICKS      = 4;
  localparam int OFF_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 100;
  localparam int LW            = $clog2(MAX_LEN + 1);

  typedef struct packed {
    logic ok;
    logic won;
    logic fl;
  } verdict_t;

  logic          clk = 1'b0;
  logic          rst, start, btn_valid;
  logic [1:0]    rnd, btn_code;
  logic          led_on, busy, round_ok, game_won, fail;
  logic [1:0]    led_code;
  logic [LW-1:0] level;

  int checks   = 0;
  int failures = 0;

  logic [1:0] model_seq[$];
  int         exp_idx;
  logic [1:0] led_q[$];
  verdict_t   verdict_q[$];

  always #5 clk = ~clk;

  random_sequence_game #(
    .MAX_LEN       (MAX_LEN),
    .ON_TICKS      (ON_TICKS),
    .OFF_TICKS     (OFF_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rnd       (rnd),
    .start     (start),
    .btn_valid (btn_valid),
    .btn_code  (btn_code),
    .led_on    (led_on),
    .led_code  (led_code),
    .busy      (busy),
    .round_ok  (round_ok),
    .game_won  (game_won),
    .fail      (fail),
    .level     (level)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; btn_valid = 1'b0; rnd = 2'd0; btn_code = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_seq.delete(); led_q.delete(); verdict_q.delete();
    exp_idx = 0;
    @(negedge clk);
  endtask

  // Drive one start pulse with rnd valid on the ADD edge; lands in SHOW_ON cycle 1.
  task automatic add_round(input logic [1:0] code);
    start = 1'b1; rnd = code;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rnd = ~code;
    model_seq.push_back(code);
    foreach (model_seq[i]) led_q.push_back(model_seq[i]);
    exp_idx = 0;
    checks++;
    if (level !== LW'(model_seq.size()))
      $display("FAIL add_level: level=%0d expected=%0d", level, model_seq.size());
    if (level !== LW'(model_seq.size())) failures++;
    checks++;
    if (led_on !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL add_latency: led_on=%b busy=%b expected led_on=1 busy=1", led_on, busy);
    end
  endtask

  // Consume the playback; returns at WAIT_IN cycle 1. already_on = SHOW_ON cycles seen.
  task automatic play_back(input int already_on);
    logic [1:0] exp;
    int on_cnt, off_cnt;
    bit off_bad;
    on_cnt = already_on;
    while (led_q.size() > 0) begin
      exp = led_q.pop_front();
      checks++;
      if (led_on !== 1'b1 || led_code !== exp) begin
        failures++;
        $display("FAIL led_code: led_on=%b code=%0d expected on=1 code=%0d", led_on, led_code, exp);
      end
      while (led_on === 1'b1 && on_cnt < ON_TICKS + 4) begin
        on_cnt++;
        @(negedge clk);
      end
      checks++;
      if (on_cnt != ON_TICKS) begin
        failures++;
        $display("FAIL on_ticks: shown=%0d expected=%0d", on_cnt, ON_TICKS);
      end
      on_cnt  = 0;
      off_cnt = 0;
      off_bad = 1'b0;
      while (led_on !== 1'b1 && off_cnt < OFF_TICKS) begin
        if (led_code !== 2'd0 || busy !== 1'b1) off_bad = 1'b1;
        off_cnt++;
        @(negedge clk);
      end
      checks++;
      if (off_bad || off_cnt != OFF_TICKS || led_on !== (led_q.size() > 0)) begin
        failures++;
        $display("FAIL off_ticks: blank=%0d bad=%0b led_on=%b expected blank=%0d led_on=%0b",
                 off_cnt, off_bad, led_on, OFF_TICKS, led_q.size() > 0);
      end
    end
  endtask

  task automatic press(input logic [1:0] code);
    verdict_t v, got;
    v = '0;
    if (code != model_seq[exp_idx]) begin
      v.fl = 1'b1; model_seq.delete(); exp_idx = 0;
    end else if (exp_idx < model_seq.size() - 1) begin
      exp_idx++;
    end else begin
      v.ok = 1'b1; exp_idx = 0;
      if (model_seq.size() == MAX_LEN) begin
        v.won = 1'b1; model_seq.delete();
      end
    end
    verdict_q.push_back(v);
    btn_valid = 1'b1; btn_code = code;
    @(negedge clk);
    btn_valid = 1'b0;
    got = verdict_q.pop_front();
    checks++;
    if ({round_ok, game_won, fail} !== got) begin
      failures++;
      $display("FAIL press_pulses: ok/won/fail=%b%b%b expected=%b", round_ok, game_won, fail, got);
    end
    checks++;
    if (busy !== !(got.ok | got.fl) || level !== LW'(model_seq.size())) begin
      failures++;
      $display("FAIL press_state: busy=%b level=%0d expected busy=%b level=%0d",
               busy, level, !(got.ok | got.fl), model_seq.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; btn_valid = 1'b0; rnd = 2'd0; btn_code = 2'd0;
    @(negedge clk);
    checks++;
    if ({led_on, led_code, busy, round_ok, game_won, fail, level} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: on=%b code=%0d busy=%b ok=%b won=%b fail=%b level=%0d expected all 0",
               led_on, led_code, busy, round_ok, game_won, fail, level);
    end
    do_reset();
    checks++;
    if (busy !== 1'b0 || level !== '0) begin
      failures++;
      $display("FAIL reset_release: busy=%b level=%0d expected 0 0", busy, level);
    end
  endtask

  task automatic test_single_round();
    do_reset();
    add_round(2'd2);
    play_back(0);
    press(2'd2);
    @(negedge clk);
    checks++;
    if (round_ok !== 1'b0 || level !== LW'(1)) begin
      failures++;
      $display("FAIL pulse_width: round_ok=%b level=%0d expected 0 1", round_ok, level);
    end
  endtask

  task automatic test_fail_sequence();
    do_reset();
    add_round(2'd1); play_back(0); press(2'd1);
    add_round(2'd3); play_back(0); press(2'd1); press(2'd3);
    add_round(2'd0); play_back(0); press(2'd1); press(2'd3); press(2'd2);
    checks++;
    if (fail !== 1'b1 || level !== '0) begin
      failures++;
      $display("FAIL wrong_code: fail=%b level=%0d expected 1 0", fail, level);
    end
  endtask

  task automatic test_game_won();
    logic [1:0] seq_copy[$];
    do_reset();
    for (int r = 0; r < MAX_LEN; r++) begin
      add_round(2'($urandom_range(3, 0)));
      play_back(0);
      seq_copy = model_seq;
      foreach (seq_copy[i]) press(seq_copy[i]);
    end
    checks++;
    if (round_ok !== 1'b1 || game_won !== 1'b1 || level !== '0) begin
      failures++;
      $display("FAIL game_won: ok=%b won=%b level=%0d expected 1 1 0", round_ok, game_won, level);
    end
  endtask

  task automatic test_ignored_inputs();
    do_reset();
    btn_valid = 1'b1; btn_code = 2'd1;
    @(negedge clk);
    btn_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== '0 || fail !== 1'b0 || round_ok !== 1'b0) begin
      failures++;
      $display("FAIL idle_press: busy=%b level=%0d fail=%b ok=%b expected all 0", busy, level, fail, round_ok);
    end
    start = 1'b1; rnd = 2'd3; btn_valid = 1'b1; btn_code = 2'd0;
    @(negedge clk);
    start = 1'b0; btn_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || fail !== 1'b0) begin
      failures++;
      $display("FAIL start_and_press: busy=%b fail=%b expected 1 0", busy, fail);
    end
    @(negedge clk);
    rnd = 2'd0;
    model_seq.push_back(2'd3);
    led_q.push_back(2'd3);
    exp_idx = 0;
    start = 1'b1; rnd = 2'd1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (level !== LW'(1) || led_on !== 1'b1 || led_code !== 2'd3) begin
      failures++;
      $display("FAIL start_in_show: level=%0d on=%b code=%0d expected 1 1 3", level, led_on, led_code);
    end
    play_back(1);
    press(2'd3);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== LW'(1)) begin
      failures++;
      $display("FAIL no_queued_start: busy=%b level=%0d expected 0 1", busy, level);
    end
  endtask

  task automatic test_reset_mid_round();
    do_reset();
    add_round(2'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (led_on !== 1'b0 || busy !== 1'b0 || level !== '0 || led_code !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: on=%b busy=%b level=%0d code=%0d expected all 0", led_on, busy, level, led_code);
    end
    @(negedge clk);
    rst = 1'b0;
    model_seq.delete(); led_q.delete();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || level !== '0) begin
      failures++;
      $display("FAIL post_reset: busy=%b level=%0d expected 0 0", busy, level);
    end
  endtask

`ifdef SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int cyc;
    do_reset();
    add_round(2'd1);
    play_back(0);
    cyc = 0;
    while (fail !== 1'b1 && cyc < TIMEOUT_TICKS + 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != TIMEOUT_TICKS || level !== '0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout: cycles=%0d level=%0d busy=%b expected %0d 0 0", cyc, level, busy, TIMEOUT_TICKS);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_round();
    test_fail_sequence();
    test_game_won();
    test_ignored_inputs();
    test_reset_mid_round();
`ifdef SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/random_sequence_game.md
# random_sequence_game

Downstream consumer of the 2-bit pseudo-random stream. Builds a growing "repeat-after-me" sequence by sampling `rnd` once per round, plays the sequence back as timed LED codes, then checks the player's button codes against it. Sits between the random generator and the LED/button I/O of the game top level.

## Interface
- `MAX_LEN`, 16: maximum sequence length; power of two, 2..64.
- `ON_TICKS`, 25_000_000: clock cycles an LED code is shown.
- `OFF_TICKS`, 12_500_000: blank clock cycles after each code.
- `TIMEOUT_TICKS`, 250_000_000: per-press input timeout (only with `SEQ_TIMEOUT_EN`).
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `rnd` in 2: random code from the generator; sampled, never held.
- `start` in 1: single-cycle pulse; begins the next round.
- `btn_valid` in 1: single-cycle pulse; player pressed a button.
- `btn_code` in 2: code of the pressed button, valid with `btn_valid`.
- `led_on` out 1: LED code currently displayed.
- `led_code` out 2: code to display; 0 when `led_on`=0.
- `busy` out 1: high in every state except IDLE.
- `round_ok` out 1: one-cycle pulse, round repeated correctly.
- `game_won` out 1: one-cycle pulse, round of length `MAX_LEN` completed.
- `fail` out 1: one-cycle pulse, wrong code or timeout.
- `level` out $clog2(MAX_LEN+1): current sequence length.

## Operation
- States: IDLE, ADD, SHOW_ON, SHOW_OFF, WAIT_IN.
- Reset: state IDLE, `len`=0, `idx`=0, tick counter 0; all outputs 0; buffer contents don't-care.
- IDLE: `start`=1 -> ADD. `btn_valid` ignored.
- ADD (1 cycle): `buf[len]`<=`rnd`, `len`<=`len`+1, `idx`<=0 -> SHOW_ON.
- SHOW_ON: `led_on`=1, `led_code`=`buf[idx]` for exactly `ON_TICKS` cycles -> SHOW_OFF.
- SHOW_OFF: `led_on`=0 for `OFF_TICKS` cycles; then `idx`==`len`-1 -> WAIT_IN with `idx`<=0, else `idx`+1 -> SHOW_ON.
- WAIT_IN, on `btn_valid`:
  - `btn_code`!=`buf[idx]` -> `fail`, `len`<=0 -> IDLE.
  - match, `idx`<`len`-1 -> `idx`+1, stay.
  - match, `idx`==`len`-1, `len`<`MAX_LEN` -> `round_ok` -> IDLE (`len` kept).
  - match, `idx`==`len`-1, `len`==`MAX_LEN` -> `round_ok` and `game_won` together, `len`<=0 -> IDLE.
- `start` outside IDLE and `btn_valid` outside WAIT_IN are ignored (no queueing).
- `start` and `btn_valid` in the same IDLE cycle: start taken, press dropped.
- `level` = `len` at all times; `len` never exceeds `MAX_LEN`.
- `rst` mid-round: immediate return to reset values, pulses cleared.

## Timing
- `start` sampled at edge N -> ADD at N+1, `led_on` high from N+2.
- One code = `ON_TICKS`+`OFF_TICKS` cycles; playback of length L = L·(`ON_TICKS`+`OFF_TICKS`) cycles.
- `round_ok`/`game_won`/`fail` registered: high exactly the cycle after the deciding `btn_valid`; `busy` low the same cycle.
- Tick counter width $clog2(max of tick parameters); reloaded on every state entry.

## Configuration
- `SEQ_TIMEOUT_EN` defined: in WAIT_IN a counter restarts on entry and on each accepted press; reaching `TIMEOUT_TICKS` -> `fail`, `len`<=0 -> IDLE.
- Undefined: WAIT_IN waits indefinitely; timeout counter and parameter unused.

## Structure
- Package `seq_game_pkg`: state enum, code width constant (2), helper for counter widths.
- Sub-module `seq_mem`: `MAX_LEN`×2-bit register file, one synchronous write port, one combinational read port; no reset on storage.

## Test plan
- Reset, `rnd`=2, `start` -> `level`=1, one SHOW_ON of `led_code`=2 for `ON_TICKS` cycles, then WAIT_IN; `btn_code`=2 -> `round_ok` pulse, `level` stays 1.
- Three rounds with `rnd`=1,3,0 -> third playback shows 1,3,0; presses 1,3,2 -> `fail` on third press, `level`=0.
- `MAX_LEN`=4, four correct rounds -> `round_ok` and `game_won` same cycle, `level`=0.
- `start` during SHOW_ON and `btn_valid` in IDLE -> no state, `len`, or output change.
- Reset asserted in SHOW_ON -> `led_on`=0, `busy`=0, `level`=0 before next edge.
- `SEQ_TIMEOUT_EN`, `TIMEOUT_TICKS`=100, no press -> `fail` exactly 100 cycles after WAIT_IN entry.
